// File: rtl/axi4l_req_arbiter_if.sv
// AXI4-Lite bundle shared between the request arbiter (master) and a slave.
// Single-beat transfers only; no burst or ID signals.
interface axi4l_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                      awvalid;
  logic                      awready;
  logic [ADDR_WIDTH-1:0]     awaddr;
  logic [2:0]                awprot;
  logic                      wvalid;
  logic                      wready;
  logic [DATA_WIDTH-1:0]     wdata;
  logic [DATA_WIDTH/8-1:0]   wstrb;
  logic                      bvalid;
  logic                      bready;
  logic [1:0]                bresp;
  logic                      arvalid;
  logic                      arready;
  logic [ADDR_WIDTH-1:0]     araddr;
  logic [2:0]                arprot;
  logic                      rvalid;
  logic                      rready;
  logic [DATA_WIDTH-1:0]     rdata;
  logic [1:0]                rresp;

  modport master (
    output awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready, arvalid, araddr, arprot, rready,
    input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
  );

  modport slave (
    input  awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready, arvalid, araddr, arprot, rready,
    output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
  );
endinterface

// File: rtl/axi4l_req_arbiter.sv
// Round-robin arbiter sharing one AXI4-Lite master among NUM_REQ single-beat clients.
// Handshake: a transfer happens on the rising edge where valid and ready are both high.
module axi4l_req_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                          aclk,
  input  logic                          areset,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ-1:0]            req_write,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic [NUM_REQ-1:0]            rsp_valid,
  output logic [DATA_WIDTH-1:0]         rsp_rdata,
  output logic [1:0]                    rsp_resp,
  output logic                          busy,
  output logic [2:0]                    dbg_state,
  axi4l_if.master                       m_axi
);
  localparam int IW = $clog2(NUM_REQ);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WR    = 3'd1,
    S_WRESP = 3'd2,
    S_RD    = 3'd3,
    S_RDATA = 3'd4
  } state_e;

  state_e                  state_q, state_d;
  logic [IW-1:0]           last_q, last_d;
  logic [IW-1:0]           gnt_q, gnt_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic                    aw_done_q, aw_done_d;
  logic                    w_done_q, w_done_d;
  logic [NUM_REQ-1:0]      rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic [1:0]              rsp_resp_q, rsp_resp_d;
  logic [IW-1:0]           pick;
  logic                    pick_vld;
  logic                    aw_hs, w_hs;

  // First valid requester scanning upward from last+1 with wrap-around.
  always_comb begin
    int idx;
    idx      = 0;
    pick     = '0;
    pick_vld = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = int'(last_q) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!pick_vld && req_valid[idx]) begin
        pick_vld = 1'b1;
        pick     = IW'(idx);
      end
    end
  end

  assign aw_hs = m_axi.awvalid && m_axi.awready;
  assign w_hs  = m_axi.wvalid && m_axi.wready;

  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    gnt_d       = gnt_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    aw_done_d   = aw_done_q;
    w_done_d    = w_done_q;
    rsp_valid_d = '0;
    rsp_rdata_d = rsp_rdata_q;
    rsp_resp_d  = rsp_resp_q;
    req_ready   = '0;
    case (state_q)
      S_IDLE: begin
        if (pick_vld) begin
          req_ready[pick] = !areset;
          last_d          = pick;
          gnt_d           = pick;
          addr_d          = req_addr[pick*ADDR_WIDTH +: ADDR_WIDTH];
          wdata_d         = req_wdata[pick*DATA_WIDTH +: DATA_WIDTH];
          aw_done_d       = 1'b0;
          w_done_d        = 1'b0;
          state_d         = req_write[pick] ? S_WR : S_RD;
        end
      end
      S_WR: begin
        // AW and W complete independently, in either order or together.
        aw_done_d = aw_done_q | aw_hs;
        w_done_d  = w_done_q | w_hs;
        if (aw_done_d && w_done_d) state_d = S_WRESP;
      end
      S_WRESP: begin
        if (m_axi.bvalid) begin
          state_d            = S_IDLE;
          rsp_valid_d[gnt_q] = 1'b1;
          rsp_resp_d         = m_axi.bresp;
          rsp_rdata_d        = '0;
        end
      end
      S_RD: begin
        if (m_axi.arready) state_d = S_RDATA;
      end
      S_RDATA: begin
        if (m_axi.rvalid) begin
          state_d            = S_IDLE;
          rsp_valid_d[gnt_q] = 1'b1;
          rsp_resp_d         = m_axi.rresp;
          rsp_rdata_d        = m_axi.rdata;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q     <= S_IDLE;
      last_q      <= IW'(NUM_REQ - 1);
      gnt_q       <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      aw_done_q   <= 1'b0;
      w_done_q    <= 1'b0;
      rsp_valid_q <= '0;
      rsp_rdata_q <= '0;
      rsp_resp_q  <= '0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      gnt_q       <= gnt_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      aw_done_q   <= aw_done_d;
      w_done_q    <= w_done_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_resp_q  <= rsp_resp_d;
    end
  end

  // Bus outputs depend only on registered state, never on req_* inputs.
  assign m_axi.awvalid = (state_q == S_WR) && !aw_done_q;
  assign m_axi.wvalid  = (state_q == S_WR) && !w_done_q;
  assign m_axi.bready  = (state_q == S_WRESP);
  assign m_axi.arvalid = (state_q == S_RD);
  assign m_axi.rready  = (state_q == S_RDATA);
  assign m_axi.awaddr  = addr_q;
  assign m_axi.araddr  = addr_q;
  assign m_axi.wdata   = wdata_q;
  assign m_axi.wstrb   = '1;
  assign m_axi.awprot  = 3'b000;
  assign m_axi.arprot  = 3'b000;

  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_resp  = rsp_resp_q;
  assign busy      = (state_q != S_IDLE);
  assign dbg_state = state_q;
endmodule

// File: tb/tb_axi4l_req_arbiter.sv
// Directed bench for axi4l_req_arbiter with a small AXI4-Lite slave model
// whose handshake delays and response codes are controlled per test.
module tb_axi4l_req_arbiter;
  localparam int NR = 4;
  localparam int DW = 32;
  localparam int AW = 32;
  localparam int RW = NR + 2 + DW;

  // ---------------- clock / reset ----------------
  logic aclk = 1'b0;
  logic areset = 1'b1;
  always #5 aclk = ~aclk;

  int cyc = 0;
  always @(posedge aclk) cyc <= cyc + 1;

  logic [NR-1:0]    req_valid, req_write, req_ready, rsp_valid;
  logic [NR*AW-1:0] req_addr;
  logic [NR*DW-1:0] req_wdata;
  logic [DW-1:0]    rsp_rdata;
  logic [1:0]       rsp_resp;
  logic             busy;
  logic [2:0]       dbg_state;

  axi4l_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) axi ();

  axi4l_req_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .aclk      (aclk),
    .areset    (areset),
    .req_valid (req_valid),
    .req_write (req_write),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_resp  (rsp_resp),
    .busy      (busy),
    .dbg_state (dbg_state),
    .m_axi     (axi)
  );

  // ---------------- slave model ----------------
  int         aw_delay = 0, w_delay = 0;
  logic       b_hold = 1'b0;
  logic [1:0] slv_bresp = 2'b00;
  int         aw_cnt, w_cnt;
  logic       aw_got, w_got, s_bvalid, s_rvalid;
  logic [AW-1:0] s_awaddr;
  logic [DW-1:0] s_wdata, s_rdata;
  logic [DW-1:0] mem [16];

  wire s_aw_hs = axi.awvalid && axi.awready;
  wire s_w_hs  = axi.wvalid && axi.wready;
  wire s_ar_hs = axi.arvalid && axi.arready;
  wire [AW-1:0] s_addr_now = aw_got ? s_awaddr : axi.awaddr;
  wire [DW-1:0] s_data_now = w_got ? s_wdata : axi.wdata;

  assign axi.awready = axi.awvalid && !aw_got && (aw_cnt >= aw_delay);
  assign axi.wready  = axi.wvalid && !w_got && (w_cnt >= w_delay);
  assign axi.bvalid  = s_bvalid;
  assign axi.bresp   = slv_bresp;
  assign axi.arready = axi.arvalid && !s_rvalid;
  assign axi.rvalid  = s_rvalid;
  assign axi.rdata   = s_rdata;
  assign axi.rresp   = 2'b00;

  always @(posedge aclk) begin
    if (areset) begin
      aw_got <= 1'b0; w_got <= 1'b0; s_bvalid <= 1'b0; s_rvalid <= 1'b0;
      aw_cnt <= 0; w_cnt <= 0; s_awaddr <= '0; s_wdata <= '0; s_rdata <= '0;
      for (int k = 0; k < 16; k++) mem[k] <= 32'hA000_0000 + k;
    end else begin
      if (s_aw_hs) begin aw_got <= 1'b1; s_awaddr <= axi.awaddr; aw_cnt <= 0; end
      else if (axi.awvalid) aw_cnt <= aw_cnt + 1;
      if (s_w_hs) begin w_got <= 1'b1; s_wdata <= axi.wdata; w_cnt <= 0; end
      else if (axi.wvalid) w_cnt <= w_cnt + 1;
      if ((aw_got || s_aw_hs) && (w_got || s_w_hs) && !s_bvalid && !b_hold) begin
        s_bvalid <= 1'b1;
        mem[s_addr_now[5:2]] <= s_data_now;
        aw_got <= 1'b0;
        w_got  <= 1'b0;
      end else if (s_bvalid && axi.bready) s_bvalid <= 1'b0;
      if (s_ar_hs) begin s_rvalid <= 1'b1; s_rdata <= mem[axi.araddr[5:2]]; end
      else if (s_rvalid && axi.rready) s_rvalid <= 1'b0;
    end
  end

  // ---------------- checking ----------------
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  logic [RW-1:0] exp_q[$];
  int gnt_log[$];
  int aw_hs_n = 0, w_hs_n = 0, ar_hs_n = 0, awv_cyc = 0, wv_cyc = 0, rsp_n = 0, rdy_cyc = 0;
  int b_early_n = 0, w_unstable_n = 0, acc_cyc = 0, rsp_cyc = 0;
  logic [AW-1:0] mon_awaddr = '0, mon_araddr = '0;
  logic [DW-1:0] mon_wdata = '0, prev_wdata = '0;
  logic [3:0]    mon_wstrb = '0;
  logic [2:0]    mon_awprot = '0, mon_arprot = '0;
  logic          w_seen = 1'b0, prev_wstall = 1'b0;

  always @(negedge aclk) begin
    #2;
    if (req_ready != '0) rdy_cyc++;
    for (int i = 0; i < NR; i++)
      if (req_valid[i] && req_ready[i]) begin
        gnt_log.push_back(i);
        acc_cyc = cyc;
      end
    if (areset) begin
      w_seen = 1'b0;
      prev_wstall = 1'b0;
    end else begin
      if (axi.awvalid) awv_cyc++;
      if (axi.awvalid && axi.awready) begin
        aw_hs_n++; mon_awaddr = axi.awaddr; mon_awprot = axi.awprot;
      end
      if (axi.wvalid) begin
        wv_cyc++;
        if (prev_wstall && (axi.wdata !== prev_wdata)) w_unstable_n++;
      end
      prev_wstall = axi.wvalid && !axi.wready;
      prev_wdata  = axi.wdata;
      if (axi.wvalid && axi.wready) begin
        w_hs_n++; mon_wdata = axi.wdata; mon_wstrb = axi.wstrb; w_seen = 1'b1;
      end
      if (axi.bready && !w_seen) b_early_n++;
      if (axi.bready && axi.bvalid) w_seen = 1'b0;
      if (axi.arvalid && axi.arready) begin
        ar_hs_n++; mon_araddr = axi.araddr; mon_arprot = axi.arprot;
      end
    end
    if (rsp_valid != '0) begin
      rsp_n++;
      rsp_cyc = cyc;
      if (exp_q.size() == 0) check("rsp_unexpected", 64'(rsp_valid), 64'd0);
      else check("rsp", 64'({rsp_valid, rsp_resp, rsp_rdata}), 64'(exp_q.pop_front()));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic issue(input int i, input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
    bit done = 1'b0;
    req_write[i] = wr;
    req_addr[i*AW +: AW]  = a;
    req_wdata[i*DW +: DW] = d;
    req_valid[i] = 1'b1;
    for (int c = 0; c < 400 && !done; c++) begin
      #1;
      if (req_ready[i]) begin
        @(posedge aclk); #1;
        req_valid[i] = 1'b0;
        done = 1'b1;
      end else @(negedge aclk);
    end
    if (!done) begin
      check("accept_timeout", 64'(i), 64'd99);
      req_valid[i] = 1'b0;
    end
  endtask

  task automatic issue2(input int i, input logic [AW-1:0] a);
    issue(i, 1'b0, a, '0);
    issue(i, 1'b0, a, '0);
  endtask

  task automatic wait_rsp(input int n, input string tag);
    for (int c = 0; c < 200 && rsp_n < n; c++) begin @(negedge aclk); #3; end
    check(tag, 64'(rsp_n), 64'(n));
  endtask

  task automatic do_reset();
    @(posedge aclk); #1;
    areset = 1'b1;
    repeat (2) @(posedge aclk);
    #1 areset = 1'b0;
  endtask

  function automatic logic [RW-1:0] rsp_word(input int i, input logic [1:0] r, input logic [DW-1:0] d);
    logic [NR-1:0] oh;
    oh = '0;
    oh[i] = 1'b1;
    return {oh, r, d};
  endfunction

  // ---------------- directed tests ----------------
  int r0, aw0, w0, ar0, awv0, wv0, rdy0, be0, wu0, base, t3_run, t3_max;

  initial begin
    req_valid = '0; req_write = '0; req_addr = '0; req_wdata = '0;

    // reset values, with requests pending to show req_ready is held off
    req_valid = '1;
    repeat (3) @(posedge aclk);
    @(negedge aclk); #3;
    check("rst_req_ready", 64'(req_ready), 64'd0);
    check("rst_rsp", 64'({rsp_valid, rsp_resp, rsp_rdata}), 64'd0);
    check("rst_busy_state", 64'({busy, dbg_state}), 64'd0);
    check("rst_axi_ctl", 64'({axi.awvalid, axi.wvalid, axi.bready, axi.arvalid, axi.rready}), 64'd0);
    check("rst_axi_data", 64'({axi.awaddr, axi.wdata}), 64'd0);
    check("rst_araddr_prot", 64'({axi.araddr, axi.awprot, axi.arprot}), 64'd0);
    check("rst_wstrb", 64'(axi.wstrb), 64'hF);
    @(posedge aclk); #1;
    areset = 1'b0;
    req_valid = '0;

    // 1: req0 write
    r0 = rsp_n; aw0 = aw_hs_n; w0 = w_hs_n; rdy0 = rdy_cyc;
    exp_q.push_back(rsp_word(0, 2'b00, 32'h0));
    issue(0, 1'b1, 32'h4, 32'hDEAD_BEEF);
    wait_rsp(r0 + 1, "t1_rsp_count");
    check("t1_latency", 64'(rsp_cyc - acc_cyc), 64'd3);
    repeat (3) @(negedge aclk);
    #3;
    check("t1_ready_cycles", 64'(rdy_cyc - rdy0), 64'd1);
    check("t1_aw_count", 64'(aw_hs_n - aw0), 64'd1);
    check("t1_w_count", 64'(w_hs_n - w0), 64'd1);
    check("t1_awaddr", 64'(mon_awaddr), 64'h4);
    check("t1_wdata", 64'(mon_wdata), 64'hDEAD_BEEF);
    check("t1_wstrb_prot", 64'({mon_wstrb, mon_awprot}), 64'({4'hF, 3'b000}));

    // 2: req2 reads back
    r0 = rsp_n; ar0 = ar_hs_n;
    exp_q.push_back(rsp_word(2, 2'b00, 32'hDEAD_BEEF));
    @(posedge aclk); #1;
    issue(2, 1'b0, 32'h4, '0);
    wait_rsp(r0 + 1, "t2_rsp_count");
    check("t2_latency", 64'(rsp_cyc - acc_cyc), 64'd3);
    repeat (3) @(negedge aclk);
    #3;
    check("t2_ar_count", 64'(ar_hs_n - ar0), 64'd1);
    check("t2_araddr_prot", 64'({mon_araddr, mon_arprot}), 64'({32'h4, 3'b000}));

    // 3: all four hold reads continuously
    do_reset();
    base = gnt_log.size(); r0 = rsp_n;
    t3_run = 0; t3_max = 0;
    for (int r = 0; r < 2; r++)
      for (int i = 0; i < NR; i++) exp_q.push_back(rsp_word(i, 2'b00, 32'hA000_0008 + i));
    fork
      issue2(0, 32'h20);
      issue2(1, 32'h24);
      issue2(2, 32'h28);
      issue2(3, 32'h2C);
      begin
        int cnt;
        cnt = 0;
        for (int c = 0; c < 300; c++) begin
          @(negedge aclk); #3;
          if (rsp_valid != '0) cnt++;
          if (cnt >= 8) break;
          if (!busy) t3_run++;
          else t3_run = 0;
          if (t3_run > t3_max) t3_max = t3_run;
        end
      end
    join
    wait_rsp(r0 + 8, "t3_rsp_count");
    for (int k = 0; k < 8; k++) check($sformatf("t3_grant%0d", k), 64'(gnt_log[base+k]), 64'(k % NR));
    check("t3_idle_gap", 64'(t3_max), 64'd1);

    // 4: W delayed 5 cycles, AW immediate, slave returns SLVERR
    @(posedge aclk); #1;
    w_delay = 5; slv_bresp = 2'b10;
    r0 = rsp_n; awv0 = awv_cyc; wv0 = wv_cyc; be0 = b_early_n; wu0 = w_unstable_n;
    exp_q.push_back(rsp_word(1, 2'b10, 32'h0));
    issue(1, 1'b1, 32'h30, 32'h1234_5678);
    wait_rsp(r0 + 1, "t4_rsp_count");
    repeat (3) @(negedge aclk);
    #3;
    check("t4_rsp_once", 64'(rsp_n - r0), 64'd1);
    check("t4_awvalid_cycles", 64'(awv_cyc - awv0), 64'd1);
    check("t4_wvalid_cycles", 64'(wv_cyc - wv0), 64'd6);
    check("t4_wdata_stable", 64'(w_unstable_n - wu0), 64'd0);
    check("t4_bready_early", 64'(b_early_n - be0), 64'd0);
    check("t4_wdata", 64'(mon_wdata), 64'h1234_5678);
    @(posedge aclk); #1;
    w_delay = 0; slv_bresp = 2'b00;

    // 5: reset while waiting in WRESP
    b_hold = 1'b1;
    r0 = rsp_n;
    issue(2, 1'b1, 32'h34, 32'h55AA_55AA);
    for (int c = 0; c < 50 && !axi.bready; c++) begin @(negedge aclk); #3; end
    check("t5_in_wresp", 64'(axi.bready), 64'd1);
    @(posedge aclk); #1;
    areset = 1'b1;
    @(posedge aclk);
    @(negedge aclk); #3;
    check("t5_abort_ctl", 64'({axi.awvalid, axi.wvalid, axi.bready, axi.arvalid, axi.rready}), 64'd0);
    check("t5_abort_busy_state", 64'({busy, dbg_state}), 64'd0);
    @(posedge aclk); #1;
    areset = 1'b0;
    b_hold = 1'b0;
    repeat (4) @(negedge aclk);
    #3;
    check("t5_no_rsp", 64'(rsp_n - r0), 64'd0);
    base = gnt_log.size(); r0 = rsp_n;
    exp_q.push_back(rsp_word(1, 2'b00, 32'hA000_0002));
    exp_q.push_back(rsp_word(3, 2'b00, 32'hA000_0003));
    @(posedge aclk); #1;
    fork
      issue(1, 1'b0, 32'h8, '0);
      issue(3, 1'b0, 32'hC, '0);
    join
    wait_rsp(r0 + 2, "t5_rsp_count");
    check("t5_grant_first", 64'(gnt_log[base]), 64'd1);
    check("t5_grant_second", 64'(gnt_log[base+1]), 64'd3);

    // 6: req0 re-raises in its rsp cycle while req3 waits
    @(posedge aclk); #1;
    base = gnt_log.size(); r0 = rsp_n;
    exp_q.push_back(rsp_word(0, 2'b00, 32'hA000_0004));
    exp_q.push_back(rsp_word(3, 2'b00, 32'hA000_0007));
    exp_q.push_back(rsp_word(0, 2'b00, 32'hA000_0005));
    fork
      begin
        issue(0, 1'b0, 32'h10, '0);
        for (int c = 0; c < 100 && !rsp_valid[0]; c++) @(negedge aclk);
        issue(0, 1'b0, 32'h14, '0);
      end
      begin
        for (int c = 0; c < 100 && gnt_log.size() < base + 1; c++) begin @(negedge aclk); #3; end
        issue(3, 1'b0, 32'h1C, '0);
      end
    join
    wait_rsp(r0 + 3, "t6_rsp_count");
    check("t6_grant0", 64'(gnt_log[base]), 64'd0);
    check("t6_grant1", 64'(gnt_log[base+1]), 64'd3);
    check("t6_grant2", 64'(gnt_log[base+2]), 64'd0);

    repeat (5) @(negedge aclk);
    #3;
    check("sb_drain", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
